// File: rtl/shift_iter32_pkg.sv
// shift_iter32_pkg: shared widths, op encodings and FSM states for the iterative shifter
package shift_iter32_pkg;
  localparam int WIDTH = 32;
  localparam int LOGW  = 5;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/shift_iter32_stage.sv
// shift_stage: one combinational stage, shifts data by 2^k per op when en, else passes it through
//   data/k/en/op/sign in, result out; sign is the operand MSB latched at start (SRA fill)
module shift_stage
  import shift_iter32_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       k,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);
  logic [5:0]       s;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] shifted;
  always_comb begin
    s       = 6'd1 << k;
    fill    = {WIDTH{sign}} & ~({WIDTH{1'b1}} >> s);
    shifted = op == OP_SLL ? data << s :
              op == OP_SRL ? data >> s :
              op == OP_SRA ? fill | (data >> s) :
                             (data << s) | (data >> (6'd32 - s));
    result  = en ? shifted : data;
  end
endmodule

// File: rtl/shift_iter32.sv
// shift_iter32: multi-cycle 32-bit SLL/SRL/SRA/ROL resolving one shamt bit per cycle
//   clk, rst_n (async active-low); start/op/A/shamt request; busy, done pulse, OUT result register
module shift_iter32
  import shift_iter32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [LOGW-1:0]  shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT
);
  state_t           state, state_nx;
  logic [2:0]       k;
  logic [WIDTH-1:0] data, staged;
  logic [1:0]       op_r;
  logic [LOGW-1:0]  shamt_r;
  logic             sign_r, accept, last, en;
  assign accept = start && state != S_SHIFT;
  assign last   = state == S_SHIFT && k == 3'd4;
  assign en     = |(shamt_r & (5'd1 << k));
  shift_stage u_stage (
    .data  (data),
    .k     (k),
    .en    (en),
    .op    (op_r),
    .sign  (sign_r),
    .result(staged)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = state == S_SHIFT ? (last ? S_DONE : S_SHIFT) :
               start            ? S_SHIFT : S_IDLE;
  always_comb begin
    busy = state == S_SHIFT;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      op_r    <= '0;
      shamt_r <= '0;
      sign_r  <= 1'b0;
      k       <= '0;
      OUT     <= '0;
    end else if (accept) begin
      data    <= A;
      op_r    <= op;
      shamt_r <= shamt;
      sign_r  <= A[WIDTH-1];
      k       <= '0;
    end else if (state == S_SHIFT) begin
      data <= staged;
      k    <= k + 3'd1;
      if (last) OUT <= staged;
    end
  end
endmodule

// File: tb/tb_shift_iter32.sv
// tb_shift_iter32: directed self-checking bench for shift_iter32
module tb_shift_iter32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done;
  logic [31:0] OUT;
  int          checks = 0;
  int          errors = 0;
  int          edges;
  logic        busy_ok;
  logic        saw_done;

  shift_iter32 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .A    (A),
    .shamt(shamt),
    .busy (busy),
    .done (done),
    .OUT  (OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request, then scramble inputs after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [4:0] sh);
    start = 1'b1;
    op    = o;
    A     = a;
    shamt = sh;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    A     = 32'hDEADBEEF;
    shamt = ~sh;
  endtask

  // Called at the first negedge after the start edge; counts edges until done, bounded.
  task automatic wait_done(output int n, output logic bok);
    n   = 0;
    bok = 1'b1;
    while (!done && n < 12) begin
      if (!busy) bok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [4:0] sh, input logic [31:0] exp);
    launch(o, a, sh);
    wait_done(edges, busy_ok);
    chk({tag, "_latency"}, edges, 5);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 1);
    chk({tag, "_out"}, OUT, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", OUT, 32'h0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("sra_neg4", 2'b10, 32'h80000000, 5'd4, 32'hF8000000);
    chk("done_busy_low", {31'd0, busy}, 0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 0);
    run("sll_31", 2'b00, 32'h00000001, 5'd31, 32'h80000000);
    @(negedge clk);
    run("srl_28", 2'b01, 32'hF0000000, 5'd28, 32'h0000000F);
    @(negedge clk);
    run("rol_1", 2'b11, 32'h80000001, 5'd1, 32'h00000003);
    @(negedge clk);
    run("rol_8", 2'b11, 32'h12345678, 5'd8, 32'h34567812);
    @(negedge clk);
    run("sra_pos16", 2'b10, 32'h7FFFFFFF, 5'd16, 32'h00007FFF);
    @(negedge clk);
    run("sra_neg31", 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    @(negedge clk);
    run("shamt0", 2'b00, 32'h12345678, 5'd0, 32'h12345678);
    @(negedge clk);

    // start pulsed while busy must not disturb the in-flight SRL
    launch(2'b01, 32'hFFFFFFFF, 5'd8);
    start = 1'b1;
    op    = 2'b00;
    A     = 32'h0;
    shamt = 5'd31;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, busy_ok);
    chk("ignore_latency", edges + 1, 5);
    chk("ignore_out", OUT, 32'h00FFFFFF);
    @(negedge clk);
    chk("ignore_idle_done", {31'd0, done}, 0);
    chk("ignore_idle_busy", {31'd0, busy}, 0);

    // back-to-back: second run is launched in the DONE cycle of the first
    run("b2b_first", 2'b11, 32'h00000001, 5'd5, 32'h00000020);
    run("b2b_second", 2'b00, 32'h00000001, 5'd3, 32'h00000008);
    @(negedge clk);

    // reset in the middle of SHIFT aborts the operation
    launch(2'b00, 32'h00000001, 5'd31);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", OUT, 32'h0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 0);
    chk("abort_out_held", OUT, 32'h0);
    run("after_reset", 2'b01, 32'h80000000, 5'd31, 32'h00000001);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
